ddr_port_arbiter: RTL and testbench

Two-master arbiter that shares the single `ddr_ctrl` block port (`ram_en`/`ram_write`/`ram_addr`/`data_to_ram` → `ram_rdy`/`block_out`) between the cache manage unit (port 0) and a second block-level DDR master (port 1, e.g. a framebuffer/loader DMA). It sits between the masters and `ddr_ctrl` inside the CPU interface. Each transfer is one 256-bit block and is granted round-robin. Command and write data are registered for the whole transfer, and a watchdog flags a controller that never answers.

---
 rtl/ddr_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one ddr_ctrl block port between two masters.
// Command/data are registered per transfer; a watchdog flags a silent controller.
module ddr_port_arbiter #(
  parameter int ADDR_W  = 30,
  parameter int BLOCK_W = 256,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_en,
  input  logic               m0_write,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [BLOCK_W-1:0] m0_wdata,
  output logic               m0_rdy,
  output logic [BLOCK_W-1:0] m0_rdata,
  input  logic               m1_en,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [BLOCK_W-1:0] m1_wdata,
  output logic               m1_rdy,
  output logic [BLOCK_W-1:0] m1_rdata,
  output logic               ram_en,
  output logic               ram_write,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [BLOCK_W-1:0] ram_wdata,
  input  logic               ram_rdy,
  input  logic [BLOCK_W-1:0] ram_rdata,
  output logic               grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e             st_q, st_d;
  logic               last_q, last_d;
  logic               gnt_q, gnt_d;
  logic               ren_q, ren_d;
  logic               rwr_q, rwr_d;
  logic [ADDR_W-1:0]  radr_q, radr_d;
  logic [BLOCK_W-1:0] rwd_q, rwd_d;
  logic               rdy0_q, rdy0_d;
  logic               rdy1_q, rdy1_d;
  logic [BLOCK_W-1:0] rd0_q, rd0_d;
  logic [BLOCK_W-1:0] rd1_q, rd1_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pick1;

  // On a tie the port that did not win last time goes next
  assign pick1 = m1_en & (~m0_en | ~last_q);

  always_comb begin
    st_d   = st_q;
    last_d = last_q;
    gnt_d  = gnt_q;
    ren_d  = 1'b0;
    rwr_d  = rwr_q;
    radr_d = radr_q;
    rwd_d  = rwd_q;
    rdy0_d = 1'b0;
    rdy1_d = 1'b0;
    rd0_d  = rd0_q;
    rd1_d  = rd1_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    unique case (st_q)
      IDLE: begin
        if (m0_en | m1_en) begin
          st_d   = BUSY;
          ren_d  = 1'b1;
          gnt_d  = pick1;
          last_d = pick1;
          cnt_d  = '0;
          rwr_d  = pick1 ? m1_write : m0_write;
          radr_d = pick1 ? m1_addr : m0_addr;
          rwd_d  = pick1 ? m1_wdata : m0_wdata;
        end
      end
      BUSY: begin
        ren_d = 1'b1;
        if (ram_rdy) begin
          st_d  = DONE;
          ren_d = 1'b0;
          if (gnt_q) begin
            rdy1_d = 1'b1;
            if (!rwr_q) rd1_d = ram_rdata;
          end else begin
            rdy0_d = 1'b1;
            if (!rwr_q) rd0_d = ram_rdata;
          end
        end else if (WD_EN && cnt_q != TMAX) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == TMAX) err_d = 1'b1;
        end
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    busy_d = (st_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      last_q <= 1'b1;
      gnt_q  <= 1'b0;
      ren_q  <= 1'b0;
      rwr_q  <= 1'b0;
      radr_q <= '0;
      rwd_q  <= '0;
      rdy0_q <= 1'b0;
      rdy1_q <= 1'b0;
      rd0_q  <= '0;
      rd1_q  <= '0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
      gnt_q  <= gnt_d;
      ren_q  <= ren_d;
      rwr_q  <= rwr_d;
      radr_q <= radr_d;
      rwd_q  <= rwd_d;
      rdy0_q <= rdy0_d;
      rdy1_q <= rdy1_d;
      rd0_q  <= rd0_d;
      rd1_q  <= rd1_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m0_rdy      = rdy0_q;
  assign m1_rdy      = rdy1_q;
  assign m0_rdata    = rd0_q;
  assign m1_rdata    = rd1_q;
  assign ram_en      = ren_q;
  assign ram_write   = rwr_q;
  assign ram_addr    = radr_q;
  assign ram_wdata   = rwd_q;
  assign grant_id    = gnt_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Randomized bench for ddr_port_arbiter against a transaction-level model.
// Model tracks round-robin winner, per-port read data and the sticky watchdog.
module tb_ddr_port_arbiter;

  localparam int AW = 30;
  localparam int BW = 256;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          m0_en, m0_write, m1_en, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [BW-1:0] m0_wdata, m1_wdata;
  logic          m0_rdy, m1_rdy;
  logic [BW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_write, ram_rdy;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_wdata, ram_rdata;
  logic          grant_id, busy, timeout_err;

  int n_cmp;
  int n_bad;

  bit            last;
  bit            err_exp;
  logic [BW-1:0] rdm [2];

  ddr_port_arbiter #(
    .ADDR_W (AW),
    .BLOCK_W(BW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .m0_en      (m0_en),
    .m0_write   (m0_write),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_rdy     (m0_rdy),
    .m0_rdata   (m0_rdata),
    .m1_en      (m1_en),
    .m1_write   (m1_write),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_rdy     (m1_rdy),
    .m1_rdata   (m1_rdata),
    .ram_en     (ram_en),
    .ram_write  (ram_write),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdy    (ram_rdy),
    .ram_rdata  (ram_rdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] got,
                     input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic scramble_inputs();
    m0_en    = 1'($urandom());
    m1_en    = 1'($urandom());
    m0_write = 1'($urandom());
    m1_write = 1'($urandom());
    m0_addr  = AW'($urandom());
    m1_addr  = AW'($urandom());
    m0_wdata = rnd_blk();
    m1_wdata = rnd_blk();
  endtask

  task automatic model_reset();
    last    = 1'b1;
    err_exp = 1'b0;
    rdm[0]  = '0;
    rdm[1]  = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ram_en"}, ram_en, 0);
    chk({tag, ".ram_write"}, ram_write, 0);
    chk({tag, ".ram_addr"}, ram_addr, 0);
    chk({tag, ".ram_wdata"}, ram_wdata, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".m0_rdy"}, m0_rdy, 0);
    chk({tag, ".m1_rdy"}, m1_rdy, 0);
    chk({tag, ".m0_rdata"}, m0_rdata, 0);
    chk({tag, ".m1_rdata"}, m1_rdata, 0);
    chk({tag, ".grant"}, grant_id, 0);
    chk({tag, ".err"}, timeout_err, 0);
  endtask

  // Called in an IDLE cycle; leaves the DUT in the IDLE cycle after DONE
  task automatic xfer(input bit e0, input bit e1, input bit w0, input bit w1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                      input int lat, input logic [BW-1:0] rd);
    bit            win;
    int            n;
    bit            wr [2];
    logic [AW-1:0] ad [2];
    logic [BW-1:0] wd [2];
    m0_en = e0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
    m1_en = e1; m1_write = w1; m1_addr = a1; m1_wdata = d1;
    ram_rdy   = 1'($urandom());
    ram_rdata = rnd_blk();
    if (!e0 && !e1) begin
      @(posedge clk); #1;
      chk("idle.ram_en", ram_en, 0);
      chk("idle.busy", busy, 0);
      chk("idle.m0_rdy", m0_rdy, 0);
      chk("idle.m1_rdy", m1_rdy, 0);
      chk("idle.m0_rdata", m0_rdata, rdm[0]);
      chk("idle.m1_rdata", m1_rdata, rdm[1]);
      return;
    end
    win  = (e0 && e1) ? !last : e1;
    last = win;
    wr[0] = w0; wr[1] = w1;
    ad[0] = a0; ad[1] = a1;
    wd[0] = d0; wd[1] = d1;
    @(posedge clk); #1;
    n = 1;
    chk("start.ram_en", ram_en, 1);
    chk("start.busy", busy, 1);
    chk("start.grant", grant_id, win);
    chk("start.ram_write", ram_write, wr[win]);
    chk("start.ram_addr", ram_addr, ad[win]);
    chk("start.ram_wdata", ram_wdata, wd[win]);
    chk("start.err", timeout_err, err_exp);
    for (int i = 0; i < lat; i++) begin
      scramble_inputs();
      if (i == 0) begin
        if (win) m1_en = 1'b0;
        else m0_en = 1'b0;
      end
      ram_rdy   = 1'b0;
      ram_rdata = rnd_blk();
      @(posedge clk); #1;
      n++;
      if (n > TO) err_exp = 1'b1;
      chk("wait.ram_en", ram_en, 1);
      chk("wait.ram_write", ram_write, wr[win]);
      chk("wait.ram_addr", ram_addr, ad[win]);
      chk("wait.ram_wdata", ram_wdata, wd[win]);
      chk("wait.rdy", {m1_rdy, m0_rdy}, 0);
      chk("wait.err", timeout_err, err_exp);
    end
    ram_rdy   = 1'b1;
    ram_rdata = rd;
    @(posedge clk); #1;
    if (!wr[win]) rdm[win] = rd;
    chk("done.m0_rdy", m0_rdy, win == 1'b0);
    chk("done.m1_rdy", m1_rdy, win == 1'b1);
    chk("done.m0_rdata", m0_rdata, rdm[0]);
    chk("done.m1_rdata", m1_rdata, rdm[1]);
    chk("done.ram_en", ram_en, 0);
    chk("done.busy", busy, 1);
    chk("done.err", timeout_err, err_exp);
    scramble_inputs();
    ram_rdy   = 1'($urandom());
    ram_rdata = rnd_blk();
    @(posedge clk); #1;
    chk("post.busy", busy, 0);
    chk("post.ram_en", ram_en, 0);
    chk("post.rdy", {m1_rdy, m0_rdy}, 0);
    chk("post.m0_rdata", m0_rdata, rdm[0]);
    chk("post.m1_rdata", m1_rdata, rdm[1]);
    chk("post.grant", grant_id, win);
    chk("post.err", timeout_err, err_exp);
  endtask

  task automatic rnd_xfer(input int maxlat);
    xfer(1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
         AW'($urandom()), AW'($urandom()), rnd_blk(), rnd_blk(),
         int'($urandom_range(0, maxlat)), rnd_blk());
  endtask

  task automatic tie_writes(input int cnt);
    for (int i = 0; i < cnt; i++)
      xfer(1'b1, 1'b1, 1'b1, 1'b1, AW'($urandom()), AW'($urandom()),
           rnd_blk(), rnd_blk(), int'($urandom_range(0, 3)), rnd_blk());
  endtask

  initial begin
    logic [BW-1:0] a5;
    n_cmp = 0;
    n_bad = 0;
    a5    = {(BW / 8){8'hA5}};
    rst   = 1'b0;
    m0_en = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_en = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    ram_rdy = 0; ram_rdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst = 1'b1;

    tie_writes(4);

    xfer(1'b1, 1'b0, 1'b0, 1'b0, AW'(30'h0000100), '0, '0, '0, 5, a5);

    xfer(1'b0, 1'b1, 1'b0, 1'b0, '0, AW'($urandom()), '0, '0, 2, rnd_blk());
    xfer(1'b0, 1'b1, 1'b0, 1'b1, '0, AW'($urandom()), '0, rnd_blk(), 3,
         rnd_blk());

    for (int i = 0; i < 4; i++)
      xfer(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 0, '0);

    for (int i = 0; i < 200; i++) rnd_xfer(6);

    xfer(1'b1, 1'b1, 1'b0, 1'b0, AW'($urandom()), AW'($urandom()),
         '0, '0, 12, rnd_blk());
    chk("wd.sticky", timeout_err, 1);
    for (int i = 0; i < 20; i++) rnd_xfer(4);

    m0_en = 1'b1; m0_write = 1'b0; m1_en = 1'b0;
    ram_rdy = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", busy, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk_zero("midrst");
    @(negedge clk);
    m0_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tie_writes(4);
    for (int i = 0; i < 30; i++) rnd_xfer(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
